// File: rtl/boruss_exec_unit.sv
// boruss_exec_unit
//   Execute/writeback datapath that sits behind the CPU FSM. It holds a
//   4x8-bit register file, an ALU, a result/flag latch that is loaded at the
//   end of EXECUTE, and a flag shadow that commits the latched flags at the
//   end of WRITEBACK. A host port loads and inspects registers during bring-up.
// Ports
//   clk, reset          clock / async active-high reset
//   current_state       FSM state (FETCH, DECODE, EXECUTE, WRITEBACK, HALT)
//   opcode, dest_reg,   decoded instruction fields
//   src_reg
//   update_registers    FSM register write enable, honoured in WRITEBACK only
//   host_we/sel/wdata   host register write port
//   host_rdata          R[host_sel], combinational
//   alu_result          latched result, also the jump target
//   alu_*_flag          latched Z/C/N flags
module boruss_exec_unit #(
  parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] current_state,
  input  logic [3:0] opcode,
  input  logic [1:0] dest_reg,
  input  logic [1:0] src_reg,
  input  logic       update_registers,
  input  logic       host_we,
  input  logic [1:0] host_sel,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic [7:0] alu_result,
  output logic       alu_zero_flag,
  output logic       alu_carry_flag,
  output logic       alu_negative_flag
);

  localparam logic [2:0] ST_EXECUTE   = 3'b010;
  localparam logic [2:0] ST_WRITEBACK = 3'b011;

  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      res_q, res_d;
  logic            zf_q, zf_d, cf_q, cf_d, nf_q, nf_d;
  logic            zs_q, zs_d, cs_q, cs_d, ns_q, ns_d;

  logic [7:0] op_a, op_b, alu_res;
  logic [8:0] sum9, diff9;
  logic       alu_z, alu_c, alu_n;
  logic       in_exec, in_wb;

  assign in_exec = (current_state == ST_EXECUTE);
  assign in_wb   = (current_state == ST_WRITEBACK);

  // ALU: operands are read in EXECUTE, so d==s simply reads the same register twice.
  always_comb begin
    op_a    = regs_q[dest_reg];
    op_b    = regs_q[src_reg];
    sum9    = {1'b0, op_a} + {1'b0, op_b};
    diff9   = {1'b0, op_a} - {1'b0, op_b};  // diff9[8] is the borrow
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (opcode)
      4'b0000: alu_res = op_b;
      4'b0001: begin alu_res = sum9[7:0];  alu_c = sum9[8];  end
      4'b0010: begin alu_res = diff9[7:0]; alu_c = diff9[8]; end
      4'b0011: alu_res = op_a & op_b;
      4'b0100: alu_res = op_a | op_b;
      4'b0101: alu_res = op_a ^ op_b;
      4'b0110: alu_res = ~op_b;
      4'b0111: begin alu_res = {op_b[6:0], 1'b0}; alu_c = op_b[7]; end
      4'b1111: begin alu_res = diff9[7:0]; alu_c = diff9[8]; end
      default: alu_res = op_b;  // jumps: target is R[s]
    endcase
    alu_z = (alu_res == 8'h00);
    alu_n = alu_res[7];
    // Jumps re-present the committed flags so WRITEBACK leaves them unchanged.
    if (opcode[3] && (opcode != 4'b1111)) begin
      alu_z = zs_q;
      alu_c = cs_q;
      alu_n = ns_q;
    end
  end

  always_comb begin
    res_d  = res_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    nf_d   = nf_q;
    zs_d   = zs_q;
    cs_d   = cs_q;
    ns_d   = ns_q;
    regs_d = regs_q;
    if (in_exec) begin
      res_d = alu_res;
      zf_d  = alu_z;
      cf_d  = alu_c;
      nf_d  = alu_n;
    end
    if (in_wb) begin
      zs_d = zf_q;
      cs_d = cf_q;
      ns_d = nf_q;
      if (update_registers) regs_d[dest_reg] = res_q;
    end else if (!in_exec && host_we) begin
      regs_d[host_sel] = host_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= {4{REG_RESET_VAL}};
      res_q  <= 8'h00;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
      nf_q   <= 1'b0;
      zs_q   <= 1'b0;
      cs_q   <= 1'b0;
      ns_q   <= 1'b0;
    end else begin
      regs_q <= regs_d;
      res_q  <= res_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
      nf_q   <= nf_d;
      zs_q   <= zs_d;
      cs_q   <= cs_d;
      ns_q   <= ns_d;
    end
  end

  assign host_rdata        = regs_q[host_sel];
  assign alu_result        = res_q;
  assign alu_zero_flag     = zf_q;
  assign alu_carry_flag    = cf_q;
  assign alu_negative_flag = nf_q;

endmodule

// File: tb/tb_boruss_exec_unit.sv
module tb_boruss_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] current_state;
  logic [3:0] opcode;
  logic [1:0] dest_reg, src_reg;
  logic       update_registers;
  logic       host_we;
  logic [1:0] host_sel;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata, alu_result;
  logic       alu_zero_flag, alu_carry_flag, alu_negative_flag;

  boruss_exec_unit #(.REG_RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .current_state(current_state), .opcode(opcode),
    .dest_reg(dest_reg), .src_reg(src_reg), .update_registers(update_registers),
    .host_we(host_we), .host_sel(host_sel), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .alu_result(alu_result), .alu_zero_flag(alu_zero_flag),
    .alu_carry_flag(alu_carry_flag), .alu_negative_flag(alu_negative_flag)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] FETCH = 3'b000, EXEC = 3'b010, WB = 3'b011;

  typedef struct packed {
    logic [7:0] res;
    logic       z, c, n;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_regs [4];
  logic       m_z, m_c, m_n;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven at the falling edge; one step crosses one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Reference ALU written directly from the opcode table.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   r;
    e.c = 1'b0;
    case (op)
      4'h0: r = b;
      4'h1: begin r = a + b; e.c = (r > 255); end
      4'h2, 4'hF: begin r = a - b; e.c = (a < b); end
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = ~b;
      4'h7: begin r = b * 2; e.c = b[7]; end
      default: r = b;
    endcase
    e.res = r[7:0];
    e.z = (e.res == 8'h00);
    e.n = e.res[7];
    if (op >= 4'h8 && op <= 4'hE) begin
      e.z = m_z; e.c = m_c; e.n = m_n;
    end
    return e;
  endfunction

  task automatic host_wr(input logic [1:0] sel, input logic [7:0] d);
    current_state = FETCH; host_we = 1'b1; host_sel = sel; host_wdata = d;
    step();
    host_we = 1'b0;
    m_regs[sel] = d;
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      host_sel = i[1:0];
      #1;
      chk($sformatf("%s_R%0d", tag, i), host_rdata, m_regs[i]);
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s, input logic upd);
    exp_t e;
    current_state = EXEC; opcode = op; dest_reg = d; src_reg = s;
    sb_q.push_back(model(op, m_regs[d], m_regs[s]));
    step();
    current_state = WB; update_registers = upd;
    e = sb_q.pop_front();
    chk("res", alu_result, e.res);
    chk("z", alu_zero_flag, e.z);
    chk("c", alu_carry_flag, e.c);
    chk("n", alu_negative_flag, e.n);
    step();
    if (upd) m_regs[d] = e.res;
    m_z = e.z; m_c = e.c; m_n = e.n;
    current_state = FETCH; update_registers = 1'b0;
    step();
    chk("hold_res", alu_result, e.res);
  endtask

  initial begin
    reset = 1'b1; current_state = FETCH; opcode = 0; dest_reg = 0; src_reg = 0;
    update_registers = 0; host_we = 0; host_sel = 0; host_wdata = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_z = 0; m_c = 0; m_n = 0;
    step(); step();
    chk("rst_res", alu_result, 8'h00);
    chk("rst_flags", {alu_zero_flag, alu_carry_flag, alu_negative_flag}, 3'b000);
    chk_regs("rst");
    reset = 1'b0;
    step();

    // ADD with carry out
    host_wr(0, 8'hF0); host_wr(1, 8'h20);
    exec(4'h1, 0, 1, 1'b1);
    chk("t1_carry", alu_carry_flag, 1'b1);
    chk_regs("t1");
    chk("t1_R0", m_regs[0], 8'h10);

    // SUB with borrow, CMP equal
    host_wr(2, 8'h05); host_wr(3, 8'h07);
    exec(4'h2, 2, 3, 1'b1);
    exec(4'hF, 3, 3, 1'b0);
    chk("t2_zero", alu_zero_flag, 1'b1);
    chk_regs("t2");

    // Jump keeps committed flags, writes nothing
    exec(4'h8, 0, 1, 1'b0);
    chk("t3_tgt", alu_result, 8'h20);
    chk("t3_zero", alu_zero_flag, 1'b1);
    chk_regs("t3");

    // SHL carry and d==s doubling
    host_wr(1, 8'h81);
    exec(4'h7, 0, 1, 1'b1);
    exec(4'h1, 1, 1, 1'b1);
    chk_regs("t4");

    // Remaining ops over assorted operands
    host_wr(0, 8'h3C); host_wr(2, 8'hA5);
    for (int op = 0; op < 16; op++) exec(op[3:0], 2'(op % 4), 2'((op + 1) % 4), 1'b1);
    chk_regs("ops");

    // Host writes blocked in EXECUTE/WRITEBACK
    current_state = EXEC; opcode = 4'hF; dest_reg = 3; src_reg = 3;
    host_we = 1'b1; host_sel = 2; host_wdata = 8'hAA;
    step();
    current_state = WB;
    step();
    current_state = FETCH; host_we = 1'b0; host_sel = 2;
    #1 chk("t5_blocked", host_rdata, m_regs[2]);
    m_z = alu_zero_flag; m_c = alu_carry_flag; m_n = alu_negative_flag;
    host_wr(2, 8'hAA);
    host_sel = 2;
    #1 chk("t5_written", host_rdata, 8'hAA);

    // Unknown state with update_registers high: nothing changes
    current_state = 3'b110; update_registers = 1'b1; dest_reg = 0; opcode = 4'h1;
    step(); step();
    update_registers = 1'b0;
    chk_regs("idle");

    // Reset during WRITEBACK discards the write
    current_state = EXEC; opcode = 4'h1; dest_reg = 0; src_reg = 1;
    step();
    current_state = WB; update_registers = 1'b1;
    #2 reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    chk("t6_res", alu_result, 8'h00);
    chk("t6_flags", {alu_zero_flag, alu_carry_flag, alu_negative_flag}, 3'b000);
    chk_regs("t6");
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
